// File: rtl/axi4_lite_req_arbiter.sv
// Two-requester round-robin arbiter driving one AXI4-Lite master port, one transaction in flight.
// Define AXI_ARB_TIMEOUT_EN to build the WAIT-state timeout (TIMEOUT_CYCLES) and sticky timeout_flag.
module axi4_lite_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_strb,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic [1:0]  req0_resp,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_strb,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic [1:0]  req1_resp,
    output logic        write_en,
    output logic        read_en,
    output logic [31:0] write_addr_in,
    output logic [31:0] read_addr_in,
    output logic [31:0] write_data_in,
    output logic [3:0]  strobe_in,
    input  logic        write_done,
    input  logic        read_done,
    input  logic [31:0] read_data_out,
    input  logic [1:0]  write_response_out,
    input  logic [1:0]  read_response_out,
    output logic        timeout_flag
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state;
    logic        last_grant;
    logic        grant_id;
    logic        lat_write;
    logic        lat_bypass;

    logic        any_valid;
    logic        grant_sel;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_strb;
    logic        done_hit;
    logic        wait_expired;
    logic        fin_valid;
    logic [31:0] fin_rdata;
    logic [1:0]  fin_resp;

    // On a tie the requester that was not granted last wins.
    assign any_valid = req0_valid | req1_valid;
    assign grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign sel_write = grant_sel ? req1_write : req0_write;
    assign sel_addr  = grant_sel ? req1_addr  : req0_addr;
    assign sel_wdata = grant_sel ? req1_wdata : req0_wdata;
    assign sel_strb  = grant_sel ? req1_strb  : req0_strb;

    // Ready is decided in the IDLE cycle itself because valid may drop at any time.
    assign req0_ready = reset_n && (state == ST_IDLE) && any_valid && !grant_sel;
    assign req1_ready = reset_n && (state == ST_IDLE) && any_valid &&  grant_sel;

    assign done_hit = lat_write ? write_done : read_done;

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] wait_cnt;
    logic          timeout_q;
    assign wait_expired = (state == ST_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = timeout_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fin_valid = 1'b0;
        fin_rdata = '0;
        fin_resp  = '0;
        if (state == ST_ISSUE && lat_bypass) begin
            fin_valid = 1'b1;
            fin_resp  = 2'b10;
        end else if (state == ST_WAIT && done_hit) begin
            fin_valid = 1'b1;
            fin_resp  = lat_write ? write_response_out : read_response_out;
            fin_rdata = lat_write ? 32'h0 : read_data_out;
        end else if (wait_expired) begin
            fin_valid = 1'b1;
            fin_resp  = 2'b11;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            lat_write     <= 1'b0;
            lat_bypass    <= 1'b0;
            write_en      <= 1'b0;
            read_en       <= 1'b0;
            write_addr_in <= '0;
            read_addr_in  <= '0;
            write_data_in <= '0;
            strobe_in     <= '0;
            req0_done     <= 1'b0;
            req0_rdata    <= '0;
            req0_resp     <= '0;
            req1_done     <= 1'b0;
            req1_rdata    <= '0;
            req1_resp     <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= '0;
            req0_resp  <= '0;
            req1_done  <= 1'b0;
            req1_rdata <= '0;
            req1_resp  <= '0;

            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_id      <= grant_sel;
                        last_grant    <= grant_sel;
                        lat_write     <= sel_write;
                        lat_bypass    <= sel_write && (sel_strb == 4'b0);
                        write_en      <= sel_write && (sel_strb != 4'b0);
                        read_en       <= !sel_write;
                        write_addr_in <= sel_write ? sel_addr  : '0;
                        read_addr_in  <= sel_write ? '0        : sel_addr;
                        write_data_in <= sel_write ? sel_wdata : '0;
                        strobe_in     <= sel_write ? sel_strb  : '0;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef AXI_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= lat_bypass ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
`ifdef AXI_ARB_TIMEOUT_EN
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_expired && !done_hit) timeout_q <= 1'b1;
`endif
                    if (fin_valid) state <= ST_RESP;
                end
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase

            if (fin_valid) begin
                write_addr_in <= '0;
                read_addr_in  <= '0;
                write_data_in <= '0;
                strobe_in     <= '0;
                req0_done     <= !grant_id;
                req1_done     <= grant_id;
                if (grant_id) begin
                    req1_rdata <= fin_rdata;
                    req1_resp  <= fin_resp;
                end else begin
                    req0_rdata <= fin_rdata;
                    req0_resp  <= fin_resp;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench for axi4_lite_req_arbiter: arbitration, latency, bypass, reset and timeout scenarios.
// Build with AXI_ARB_TIMEOUT_EN defined to exercise the timeout path instead of the endless WAIT.
module tb_axi4_lite_req_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_write, req0_ready, req0_done;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic [3:0]  req0_strb;
    logic [1:0]  req0_resp;
    logic        req1_valid, req1_write, req1_ready, req1_done;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic [3:0]  req1_strb;
    logic [1:0]  req1_resp;
    logic        write_en, read_en, write_done, read_done, timeout_flag;
    logic [31:0] write_addr_in, read_addr_in, write_data_in, read_data_out;
    logic [3:0]  strobe_in;
    logic [1:0]  write_response_out, read_response_out;

    int vectors = 0;
    int miscompares = 0;

    logic [174:0] all_outs;
    assign all_outs = {req0_ready, req0_done, req0_rdata, req0_resp,
                       req1_ready, req1_done, req1_rdata, req1_resp,
                       write_en, read_en, write_addr_in, read_addr_in,
                       write_data_in, strobe_in, timeout_flag};

    always #5 clock = ~clock;

    axi4_lite_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_ready(req0_ready),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_ready(req1_ready),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
        .write_en(write_en), .read_en(read_en), .write_addr_in(write_addr_in),
        .read_addr_in(read_addr_in), .write_data_in(write_data_in), .strobe_in(strobe_in),
        .write_done(write_done), .read_done(read_done), .read_data_out(read_data_out),
        .write_response_out(write_response_out), .read_response_out(read_response_out),
        .timeout_flag(timeout_flag)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_strb = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_strb = 0;
        write_done = 0; read_done = 0; read_data_out = 0;
        write_response_out = 0; read_response_out = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        tick();
        tick();
        vectors++;
        if (all_outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        reset_n = 1;
        settle();
        vectors++;
        if ({req1_ready, req0_ready, write_en, read_en} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_idle_quiet: got %b want 0000", {req1_ready, req0_ready, write_en, read_en});
        end
    endtask

    task automatic test_simple_read();
        req0_valid = 1; req0_write = 0; req0_addr = 32'h10;
        settle();
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL read_grant: got %b want 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 0;
        vectors++;
        if ({write_en, read_en, read_addr_in, write_addr_in} !== {1'b0, 1'b1, 32'h10, 32'h0}) begin
            miscompares++;
            $display("FAIL read_issue: got %b %b %h %h want 0 1 00000010 00000000",
                     write_en, read_en, read_addr_in, write_addr_in);
        end
        tick();
        tick();
        tick();
        vectors++;
        if ({req0_done, read_en, read_addr_in} !== {1'b0, 1'b0, 32'h10}) begin
            miscompares++;
            $display("FAIL read_wait_hold: got %b %b %h want 0 0 00000010", req0_done, read_en, read_addr_in);
        end
        read_done = 1; read_data_out = 32'hDEADBEEF; read_response_out = 2'b00;
        tick();
        read_done = 0; read_data_out = 0;
        vectors++;
        if ({req0_done, req1_done, req0_rdata, req0_resp, read_addr_in} !==
            {1'b1, 1'b0, 32'hDEADBEEF, 2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL read_done: got %b %b %h %b %h want 1 0 deadbeef 00 00000000",
                     req0_done, req1_done, req0_rdata, req0_resp, read_addr_in);
        end
        tick();
        vectors++;
        if (req0_done !== 1'b0) begin
            miscompares++;
            $display("FAIL read_done_pulse: got %b want 0", req0_done);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr, exp_data;
        logic [3:0]  exp_strb;
        logic [1:0]  exp_resp;
        reset_n = 0;
        req0_valid = 1; req0_write = 1; req0_addr = 32'h100; req0_wdata = 32'hA0A00000; req0_strb = 4'hF;
        req1_valid = 1; req1_write = 1; req1_addr = 32'h200; req1_wdata = 32'hB1B11111; req1_strb = 4'h3;
        tick();
        reset_n = 1;
        settle();
        for (int g = 0; g < 4; g++) begin
            exp_addr = (g % 2 == 1) ? 32'h200 : 32'h100;
            exp_data = (g % 2 == 1) ? 32'hB1B11111 : 32'hA0A00000;
            exp_strb = (g % 2 == 1) ? 4'h3 : 4'hF;
            exp_resp = (g % 2 == 1) ? 2'b01 : 2'b00;
            vectors++;
            if ({req1_ready, req0_ready} !== ((g % 2 == 1) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got %b want %b", g,
                         {req1_ready, req0_ready}, (g % 2 == 1) ? 2'b10 : 2'b01);
            end
            tick();
            vectors++;
            if ({write_en, read_en, write_addr_in, write_data_in, strobe_in} !==
                {1'b1, 1'b0, exp_addr, exp_data, exp_strb}) begin
                miscompares++;
                $display("FAIL contention_issue[%0d]: got %b %b %h %h %h want 1 0 %h %h %h", g,
                         write_en, read_en, write_addr_in, write_data_in, strobe_in,
                         exp_addr, exp_data, exp_strb);
            end
            tick();
            vectors++;
            if ({write_en, read_en} !== 2'b00) begin
                miscompares++;
                $display("FAIL contention_en_pulse[%0d]: got %b want 00", g, {write_en, read_en});
            end
            write_done = 1; write_response_out = exp_resp;
            tick();
            write_done = 0; write_response_out = 0;
            vectors++;
            if ({req1_done, req0_done, (g % 2 == 1) ? req1_resp : req0_resp,
                 (g % 2 == 1) ? req1_rdata : req0_rdata} !==
                {((g % 2 == 1) ? 2'b10 : 2'b01), exp_resp, 32'h0}) begin
                miscompares++;
                $display("FAIL contention_done[%0d]: got %b%b resp0=%b resp1=%b want resp %b", g,
                         req1_done, req0_done, req0_resp, req1_resp, exp_resp);
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        settle();
        tick();
    endtask

    task automatic test_zero_strobe();
        req1_valid = 1; req1_write = 1; req1_addr = 32'h300; req1_wdata = 32'h55; req1_strb = 4'h0;
        settle();
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL zstrb_grant: got %b want 10", {req1_ready, req0_ready});
        end
        tick();
        req1_valid = 0;
        vectors++;
        if ({write_en, read_en} !== 2'b00) begin
            miscompares++;
            $display("FAIL zstrb_no_pulse: got %b want 00", {write_en, read_en});
        end
        tick();
        vectors++;
        if ({req1_done, req1_resp, req1_rdata} !== {1'b1, 2'b10, 32'h0}) begin
            miscompares++;
            $display("FAIL zstrb_done: got %b %b %h want 1 10 00000000", req1_done, req1_resp, req1_rdata);
        end
        tick();
        vectors++;
        if ({req1_done, write_en} !== 2'b00) begin
            miscompares++;
            $display("FAIL zstrb_after: got %b want 00", {req1_done, write_en});
        end
    endtask

    task automatic test_stray_done();
        read_done = 1; read_data_out = 32'hBAD0BAD0; read_response_out = 2'b11;
        tick();
        read_done = 0; read_data_out = 0; read_response_out = 0;
        vectors++;
        if ({req0_done, req1_done, req0_ready, req1_ready, read_en, write_en} !== 6'b0) begin
            miscompares++;
            $display("FAIL stray_idle: got %b want 000000",
                     {req0_done, req1_done, req0_ready, req1_ready, read_en, write_en});
        end
        req0_valid = 1; req0_write = 0; req0_addr = 32'h44;
        settle();
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        tick();
        write_done = 1; write_response_out = 2'b10;
        tick();
        write_done = 0; write_response_out = 0;
        vectors++;
        if ({req0_done, read_addr_in} !== {1'b0, 32'h44}) begin
            miscompares++;
            $display("FAIL stray_wrong_type: got %b %h want 0 00000044", req0_done, read_addr_in);
        end
        tick();
        tick();
        vectors++;
        if ({req0_done, read_addr_in} !== {1'b0, 32'h44}) begin
            miscompares++;
            $display("FAIL stray_still_wait: got %b %h want 0 00000044", req0_done, read_addr_in);
        end
        read_done = 1; read_data_out = 32'h12345678; read_response_out = 2'b01;
        tick();
        read_done = 0; read_data_out = 0; read_response_out = 0;
        vectors++;
        if ({req0_done, req0_rdata, req0_resp} !== {1'b1, 32'h12345678, 2'b01}) begin
            miscompares++;
            $display("FAIL stray_final_done: got %b %h %b want 1 12345678 01", req0_done, req0_rdata, req0_resp);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        req0_valid = 1; req0_write = 0; req0_addr = 32'h80;
        settle();
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        tick();
        reset_n = 0;
        req0_valid = 1; req0_write = 1; req0_addr = 32'h500; req0_wdata = 32'h5; req0_strb = 4'hF;
        req1_valid = 1; req1_write = 1; req1_addr = 32'h600; req1_wdata = 32'h6; req1_strb = 4'hF;
        read_done = 1; read_data_out = 32'hFFFF0000;
        tick();
        read_done = 0; read_data_out = 0;
        vectors++;
        if (all_outs !== '0) begin
            miscompares++;
            $display("FAIL rstwait_outputs: got %h want 0", all_outs);
        end
        tick();
        vectors++;
        if (all_outs !== '0) begin
            miscompares++;
            $display("FAIL rstwait_no_done: got %h want 0", all_outs);
        end
        reset_n = 1;
        settle();
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rstwait_first_grant: got %b want 01", {req1_ready, req0_ready});
        end
        tick();
        vectors++;
        if ({write_en, write_addr_in} !== {1'b1, 32'h500}) begin
            miscompares++;
            $display("FAIL rstwait_issue: got %b %h want 1 00000500", write_en, write_addr_in);
        end
        reset_n = 0;
        idle_inputs();
        tick();
        reset_n = 1;
        settle();
    endtask

    task automatic test_timeout();
        int seen;
        req0_valid = 1; req0_write = 1; req0_addr = 32'h700; req0_wdata = 32'h77; req0_strb = 4'hF;
        settle();
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        tick();
`ifdef AXI_ARB_TIMEOUT_EN
        seen = -1;
        for (int k = 0; k < 20 && seen < 0; k++) begin
            if (req0_done === 1'b1) seen = k;
            else tick();
        end
        vectors++;
        if (seen != 8) begin
            miscompares++;
            $display("FAIL timeout_latency: got done at wait cycle %0d want 8", seen);
        end
        vectors++;
        if ({req0_resp, req0_rdata, timeout_flag} !== {2'b11, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_resp: got %b %h %b want 11 00000000 1", req0_resp, req0_rdata, timeout_flag);
        end
        tick();
        tick();
        vectors++;
        if ({timeout_flag, req0_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_sticky: got %b want 10", {timeout_flag, req0_done});
        end
`else
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (req0_done !== 1'b0 || timeout_flag !== 1'b0) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL timeout_disabled: got %0d cycles with done/flag high want 0", seen);
        end
        write_done = 1; write_response_out = 2'b00;
        tick();
        write_done = 0;
        vectors++;
        if ({req0_done, req0_resp, timeout_flag} !== {1'b1, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_late_done: got %b %b %b want 1 00 0", req0_done, req0_resp, timeout_flag);
        end
        tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_simple_read();
        test_contention();
        test_zero_strobe();
        test_stray_done();
        test_reset_mid_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
